adder_tree_sched: RTL and testbench
===================================

# adder_tree_sched

Round-robin scheduler that shares one pipelined `adder_tree` instance between `NUM_REQ` requesters. Each requester offers a flattened `NUM_INPUTS*DWIDTH` vector with a valid/ready handshake. The block issues at most one vector per cycle into the tree and tags it with the requester ID. It then returns the tree's sum with that ID once the tree's fixed latency has elapsed. The block sits between the front-end producers and the `adder_tree` datapath, and supports a stop/drain sequence for reconfiguration.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `NUM_INPUTS`, 16, adder_tree inputs per vector
- `DWIDTH`, 14, adder_tree input/sum width
- `TREE_LATENCY`, 4, adder_tree pipeline depth in clocks, from input edge to valid `o_sum`
- `IDW`, `$clog2(NUM_REQ)`, requester ID width (derived, localparam)

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `i_req_valid`  in  NUM_REQ  per-requester vector valid
- `i_req_vector`  in  NUM_REQ*NUM_INPUTS*DWIDTH  requester k occupies slice `[k*NUM_INPUTS*DWIDTH +: NUM_INPUTS*DWIDTH]`
- `o_req_ready`  out  NUM_REQ  one-hot grant; transfer when valid&ready
- `o_tree_vector`  out  NUM_INPUTS*DWIDTH  registered vector to `adder_tree.i_dat_vector`
- `i_tree_sum`  in  DWIDTH  from `adder_tree.o_sum`
- `o_res_valid`  out  1  result strobe, single cycle
- `o_res_id`  out  IDW  requester that owns `o_res_sum`
- `o_res_sum`  out  DWIDTH  sum, modulo 2^DWIDTH
- `i_stop`  in  1  request to stop issuing and drain
- `o_idle`  out  1  STOPPED state and no results in flight

## Operation
- States:
  - RUN: grants enabled.
  - DRAIN: no grants; waits until the in-flight count reaches 0.
  - STOPPED: `o_idle`=1.
- Transitions:
  - RUN→DRAIN when `i_stop`=1.
  - DRAIN→STOPPED when in-flight count=0.
  - STOPPED→RUN when `i_stop`=0.
  - DRAIN does not return to RUN directly, even if `i_stop` drops.
- Arbitration (RUN only):
  - `o_req_ready` is combinational from `i_req_valid`, the RR pointer and the state.
  - Grant goes to the first valid requester at or after the pointer, scanning upward and wrapping.
  - After a transfer to requester k, the pointer becomes (k+1) mod NUM_REQ.
  - With no transfer, the pointer holds.
  - Requesters must not make valid depend on ready.
- Issue: on a transfer edge, `o_tree_vector` registers the granted slice, and the tag pipeline (valid+ID, depth TREE_LATENCY+1) loads {1,k}.
- Result: the tag pipeline output drives `o_res_valid` and `o_res_id`, and `o_res_sum` registers `i_tree_sum` on the same edge. The sum is not truncated or extended further.
- In-flight counter (0..TREE_LATENCY+1):
  - +1 on issue, −1 on result.
  - Simultaneous issue and result leaves it unchanged.
- Reset (any time, including mid-operation):
  - State RUN, pointer 0, tag pipeline cleared, counter 0.
  - Results in flight are discarded; no `o_res_valid` is produced for them.

## Timing
- Throughput: one vector per clock, sustained, in RUN.
- Latency: a transfer on edge t gives `o_res_valid`=1 in the cycle after edge t+TREE_LATENCY+1.
- Reset values:
  - `o_req_ready`=0 until the first valid is seen.
  - `o_tree_vector`=0, `o_res_valid`=0, `o_res_id`=0, `o_res_sum`=0, `o_idle`=0.
- Back-to-back issues return back-to-back results in issue order. The result path has no backpressure.
- `i_stop` asserted in the same cycle as a valid: no grant that cycle (state is still RUN, but the stop takes effect combinationally).
- `o_idle` rises one cycle after the counter reaches 0 in DRAIN.

## Configuration
- `ADDER_SCHED_ZERO_IDLE_EN` defined:
  - On cycles without a transfer, `o_tree_vector` is loaded with 0.
  - The tree sees zeros and toggling is minimised.
- Not defined:
  - `o_tree_vector` holds its last value on non-transfer cycles.
  - Functional results are identical in both builds; only `o_tree_vector` contents on idle cycles differ.

## Test plan
- Single requester 2:
  - Stimulus: offers all-ones×16 (0x001 each).
  - Required: ready[2] in the same cycle; `o_res_valid` TREE_LATENCY+1 cycles after acceptance, with id=2 and sum=0x010.
- All 4 requesters continuously valid, each with a distinct constant:
  - Required: grants rotate 0,1,2,3,0…; results return every cycle with id sequence 0,1,2,3 and the correct sums.
- Overflow:
  - Stimulus: 16 inputs of 0x3FFF.
  - Required: `o_res_sum`=0x3FF0 (mod 2^14).
- Stop/drain:
  - Stimulus: assert `i_stop` after 3 back-to-back issues.
  - Required: no further ready; 3 results emerge; `o_idle`=1 one cycle after the last result; dropping `i_stop` resumes grants from the saved pointer.
- Reset mid-flight:
  - Stimulus: assert `rst` two cycles after an issue.
  - Required: no `o_res_valid` ever appears for that issue; pointer returns to 0.
- Build with and without `ADDER_SCHED_ZERO_IDLE_EN`:
  - Required: `o_tree_vector`=0 on idle cycles only in the defined build; result stream identical in both.

Source files
------------

// File: rtl/adder_tree_sched.sv
// adder_tree_sched: round-robin scheduler sharing one pipelined adder_tree
// between NUM_REQ requesters. Each accepted vector is registered toward the
// tree and tagged with its requester ID; the tag travels alongside the tree
// pipeline so the returned sum can be labelled with its owner.
// Supports a stop/drain sequence (RUN -> DRAIN -> STOPPED).
// Optional build macro: ADDER_SCHED_ZERO_IDLE_EN -- when defined, the tree
// input vector is zeroed on cycles without a transfer.
module adder_tree_sched #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_INPUTS   = 16,
    parameter int DWIDTH       = 14,
    parameter int TREE_LATENCY = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    i_req_valid,
    input  logic [NUM_REQ*NUM_INPUTS*DWIDTH-1:0]  i_req_vector,
    output logic [NUM_REQ-1:0]                    o_req_ready,
    output logic [NUM_INPUTS*DWIDTH-1:0]          o_tree_vector,
    input  logic [DWIDTH-1:0]                     i_tree_sum,
    output logic                                  o_res_valid,
    output logic [$clog2(NUM_REQ)-1:0]            o_res_id,
    output logic [DWIDTH-1:0]                     o_res_sum,
    input  logic                                  i_stop,
    output logic                                  o_idle
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int VW    = NUM_INPUTS * DWIDTH;
    // One extra tag stage covers the cycle the vector spends in o_tree_vector
    // before the tree itself starts counting its latency.
    localparam int DEPTH = TREE_LATENCY + 1;
    localparam int CW    = $clog2(TREE_LATENCY + 2);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_STOPPED
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    grant_id;
    logic              grant_any;
    logic [IDW-1:0]    cand_id;
    int unsigned       scan_idx;
    logic              xfer;
    logic [VW-1:0]     sel_vec;
    logic [DEPTH-1:0]  tag_vld;
    logic [IDW-1:0]    tag_id [DEPTH];
    logic [CW-1:0]     inflight;
    logic              res_load;

    // Round-robin arbiter: first valid requester at or after ptr, wrapping.
    always_comb begin
        grant_any   = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        scan_idx    = 0;
        o_req_ready = '0;
        if (state == S_RUN && !i_stop) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                scan_idx = (32'(ptr) + i) % NUM_REQ;
                cand_id  = IDW'(scan_idx);
                if (!grant_any && i_req_valid[cand_id]) begin
                    grant_any = 1'b1;
                    grant_id  = cand_id;
                end
            end
        end
        if (grant_any) begin
            o_req_ready[grant_id] = 1'b1;
        end
    end

    assign xfer     = grant_any;
    assign sel_vec  = i_req_vector[int'(grant_id)*VW +: VW];
    assign res_load = tag_vld[DEPTH-1];

    // Round-robin pointer: moves past the last granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            if (int'(grant_id) == NUM_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_id + 1'b1;
            end
        end
    end

    // Issue register toward the adder tree input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tree_vector <= '0;
        end else if (xfer) begin
            o_tree_vector <= sel_vec;
        end
`ifdef ADDER_SCHED_ZERO_IDLE_EN
        else begin
            o_tree_vector <= '0;
        end
`endif
    end

    // Tag pipeline (valid + ID) running in step with the tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[DEPTH-2:0], xfer};
            tag_id[0] <= grant_id;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Result registers: tag output and tree sum captured on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_res_valid <= 1'b0;
            o_res_id    <= '0;
            o_res_sum   <= '0;
        end else begin
            o_res_valid <= res_load;
            o_res_id    <= tag_id[DEPTH-1];
            o_res_sum   <= i_tree_sum;
        end
    end

    // In-flight counter: issues minus results leaving the tag pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({xfer, res_load})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; DRAIN always completes before RUN can resume.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:     if (i_stop) state_nxt = S_DRAIN;
            S_DRAIN:   if (inflight == '0) state_nxt = S_STOPPED;
            S_STOPPED: if (!i_stop) state_nxt = S_RUN;
            default:   state_nxt = S_RUN;
        endcase
    end

    assign o_idle = (state == S_STOPPED) && (inflight == '0);

endmodule

// File: tb/tb_adder_tree_sched.sv
module tb_adder_tree_sched;

    localparam int NUM_REQ      = 4;
    localparam int NUM_INPUTS   = 16;
    localparam int DWIDTH       = 14;
    localparam int TREE_LATENCY = 4;
    localparam int IDW          = 2;
    localparam int VW           = NUM_INPUTS * DWIDTH;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       i_req_valid;
    logic [NUM_REQ*VW-1:0]    i_req_vector;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic [VW-1:0]            o_tree_vector;
    logic [DWIDTH-1:0]        i_tree_sum;
    logic                     o_res_valid;
    logic [IDW-1:0]           o_res_id;
    logic [DWIDTH-1:0]        o_res_sum;
    logic                     i_stop;
    logic                     o_idle;

    adder_tree_sched #(
        .NUM_REQ      (NUM_REQ),
        .NUM_INPUTS   (NUM_INPUTS),
        .DWIDTH       (DWIDTH),
        .TREE_LATENCY (TREE_LATENCY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .i_req_vector  (i_req_vector),
        .o_req_ready   (o_req_ready),
        .o_tree_vector (o_tree_vector),
        .i_tree_sum    (i_tree_sum),
        .o_res_valid   (o_res_valid),
        .o_res_id      (o_res_id),
        .o_res_sum     (o_res_sum),
        .i_stop        (i_stop),
        .o_idle        (o_idle)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DWIDTH-1:0] vec_sum(input logic [VW-1:0] v);
        logic [DWIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_INPUTS; i++) s = s + v[i*DWIDTH +: DWIDTH];
        return s;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [DWIDTH-1:0] w);
        return {NUM_INPUTS{w}};
    endfunction

    // Behavioural adder tree: TREE_LATENCY register stages after the input vector.
    logic [DWIDTH-1:0] tree_pipe [TREE_LATENCY];
    always @(posedge clk) begin
        tree_pipe[0] <= vec_sum(o_tree_vector);
        for (int i = 1; i < TREE_LATENCY; i++) tree_pipe[i] <= tree_pipe[i-1];
    end
    assign i_tree_sum = tree_pipe[TREE_LATENCY-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and reference model of arbitration / stop sequence.
    typedef struct {
        int unsigned       id;
        logic [DWIDTH-1:0] sum;
        int unsigned       due;
    } exp_t;

    typedef enum {M_RUN, M_DRAIN, M_STOP} mstate_t;

    exp_t              sb[$];
    mstate_t           m_state = M_RUN;
    int unsigned       m_ptr   = 0;
    logic [VW-1:0]     m_vec   = '0;
    logic [DWIDTH-1:0] last_sum;
    int unsigned       last_id;

    always @(negedge clk) begin
        exp_t               e;
        logic [NUM_REQ-1:0] exp_rdy;
        int                 g;
        if (rst) begin
            sb.delete();
            m_state = M_RUN;
            m_ptr   = 0;
            m_vec   = '0;
            check_eq("res_valid_in_reset", o_res_valid, 1'b0);
        end else begin
            if (o_res_valid) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_result", o_res_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check_eq("res_id", o_res_id, e.id);
                    check_eq("res_sum", o_res_sum, e.sum);
                    check_eq("res_latency", cyc, e.due);
                    last_sum = o_res_sum;
                    last_id  = o_res_id;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check_eq("res_missing", o_res_valid, 1'b1);
                sb.delete(0);
            end

            check_eq("tree_vector", o_tree_vector, m_vec);
            check_eq("idle", o_idle, (m_state == M_STOP) && (sb.size() == 0));

            exp_rdy = '0;
            g = -1;
            if (m_state == M_RUN && !i_stop) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && i_req_valid[j]) g = j;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check_eq("ready", o_req_ready, exp_rdy);

            if (g >= 0) begin
                e.id  = g;
                e.sum = vec_sum(i_req_vector[g*VW +: VW]);
                e.due = cyc + TREE_LATENCY + 2;
                sb.push_back(e);
                m_vec = i_req_vector[g*VW +: VW];
                m_ptr = (g + 1) % NUM_REQ;
            end else begin
`ifdef ADDER_SCHED_ZERO_IDLE_EN
                m_vec = '0;
`endif
            end

            case (m_state)
                M_RUN:   if (i_stop) m_state = M_DRAIN;
                M_DRAIN: if (sb.size() == 0) m_state = M_STOP;
                M_STOP:  if (!i_stop) m_state = M_RUN;
                default: m_state = M_RUN;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        i_req_valid  = '0;
        i_req_vector = '0;
        i_stop       = 1'b0;
        step(3);
        check_eq("rst_tree_vector", o_tree_vector, '0);
        check_eq("rst_res_valid", o_res_valid, 1'b0);
        check_eq("rst_res_id", o_res_id, '0);
        check_eq("rst_res_sum", o_res_sum, '0);
        check_eq("rst_idle", o_idle, 1'b0);
        check_eq("rst_ready", o_req_ready, '0);
        rst = 1'b0;
        step(2);

        // Single requester 2, all inputs 0x001.
        i_req_vector[2*VW +: VW] = fill(14'h001);
        i_req_valid = 4'b0100;
        #1;
        check_eq("single_ready", o_req_ready, 4'b0100);
        step(1);
        i_req_valid = '0;
        step(TREE_LATENCY + 4);
        check_eq("single_sum", last_sum, 14'h010);
        check_eq("single_id", last_id, 2);

        // All four continuously valid with distinct constants.
        for (int k = 0; k < NUM_REQ; k++) i_req_vector[k*VW +: VW] = fill(DWIDTH'(k*37 + 5));
        i_req_valid = 4'b1111;
        step(12);
        i_req_valid = '0;
        step(TREE_LATENCY + 4);

        // Overflow: 16 x 0x3FFF wraps to 0x3FF0.
        i_req_vector[1*VW +: VW] = fill(14'h3FFF);
        i_req_valid = 4'b0010;
        step(1);
        i_req_valid = '0;
        step(TREE_LATENCY + 4);
        check_eq("overflow_sum", last_sum, 14'h3FF0);

        // Stop/drain after three back-to-back issues, then resume.
        i_req_valid = 4'b1111;
        step(3);
        i_stop = 1'b1;
        #1;
        check_eq("stop_blocks_grant", o_req_ready, '0);
        step(TREE_LATENCY + 6);
        check_eq("idle_after_drain", o_idle, 1'b1);
        check_eq("stopped_no_ready", o_req_ready, '0);
        i_stop = 1'b0;
        step(6);
        i_req_valid = '0;
        step(TREE_LATENCY + 4);

        // Reset two cycles after an issue: that result must never appear.
        i_req_vector[3*VW +: VW] = fill(14'h0123);
        i_req_valid = 4'b1000;
        step(1);
        i_req_valid = '0;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(TREE_LATENCY + 4);
        i_req_valid = 4'b1111;
        #1;
        check_eq("ptr_after_reset", o_req_ready, 4'b0001);
        step(5);
        i_req_valid = '0;
        step(TREE_LATENCY + 6);
        check_eq("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
